// File: rtl/tdm_demux_14.sv
// tdm_demux_14 - receive side of a 4-slot TDM lane.
// Reassembles four channels from one lane. A frame_start marker aligns
// the frame. Slots 0..2 are held in a shadow buffer. All four channels
// are published together when slot 3 arrives.
//
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   din           lane data, sampled when din_valid=1
//   din_valid     beat qualifier
//   frame_start   marks the current beat as slot 0 (only meaningful when valid)
//   out           4 channels, channel k at out[(k+1)*WIDTH-1 -: WIDTH]
//   frame_valid   one-cycle pulse: out was updated this cycle
//   sync_err      one-cycle pulse: framing violation detected
//   slot          slot index expected for the next beat
//   locked        high while frame alignment is held (RUN)
//   err_cnt       saturating count of sync_err pulses
//
// state | meaning
// HUNT  | no alignment; wait for a beat with frame_start=1
// RUN   | aligned; slot tracks the position inside the frame
module tdm_demux_14 #(
  parameter int WIDTH = 1,
  parameter int ERR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               frame_start,
  output logic [4*WIDTH-1:0] out,
  output logic               frame_valid,
  output logic               sync_err,
  output logic [1:0]         slot,
  output logic               locked,
  output logic [ERR_W-1:0]   err_cnt
);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t                  r_state;
  logic [2:0][WIDTH-1:0]   r_shadow;
  logic [4*WIDTH-1:0]      r_out;
  logic                    r_frame_valid;
  logic                    r_sync_err;
  logic [1:0]              r_slot;
  logic                    r_locked;
  logic [ERR_W-1:0]        r_err_cnt;

  logic [ERR_W-1:0]        w_err_next;

  // Saturating increment. Only used on cycles that raise sync_err.
  assign w_err_next = (r_err_cnt == {ERR_W{1'b1}}) ? r_err_cnt
                                                   : r_err_cnt + ERR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= HUNT;
      r_shadow      <= '0;
      r_out         <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_slot        <= 2'd0;
      r_locked      <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      if (din_valid) begin
        case (r_state)
          HUNT: begin
            if (frame_start) begin
              r_shadow[0] <= din;
              r_slot      <= 2'd1;
              r_state     <= RUN;
              r_locked    <= 1'b1;
            end
          end
          RUN: begin
            if (frame_start) begin
              // A marker anywhere but slot 0 drops the partial frame.
              // The beat still starts a new frame.
              if (r_slot != 2'd0) begin
                r_sync_err <= 1'b1;
                r_err_cnt  <= w_err_next;
              end
              r_shadow[0] <= din;
              r_slot      <= 2'd1;
            end else begin
              case (r_slot)
                2'd0: begin
                  r_sync_err <= 1'b1;
                  r_err_cnt  <= w_err_next;
                  r_state    <= HUNT;
                  r_locked   <= 1'b0;
                  r_slot     <= 2'd0;
                end
                2'd1: begin
                  r_shadow[1] <= din;
                  r_slot      <= 2'd2;
                end
                2'd2: begin
                  r_shadow[2] <= din;
                  r_slot      <= 2'd3;
                end
                default: begin
                  r_out         <= {din, r_shadow[2], r_shadow[1], r_shadow[0]};
                  r_frame_valid <= 1'b1;
                  r_slot        <= 2'd0;
                end
              endcase
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign out         = r_out;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign slot        = r_slot;
  assign locked      = r_locked;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_tdm_demux_14.sv
module tb_tdm_demux_14;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] din;
  logic       din_valid;
  logic       frame_start;
  logic [3:0] out;
  logic       frame_valid;
  logic       sync_err;
  logic [1:0] slot;
  logic       locked;
  logic [1:0] err_cnt;

  int n_checks = 0;
  int n_err    = 0;

  tdm_demux_14 #(.WIDTH(1), .ERR_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .out         (out),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .slot        (slot),
    .locked      (locked),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic       fs;
    logic       d;
    logic [3:0] o;
    logic       fv;
    logic       se;
    logic [1:0] sl;
    logic       lk;
    logic [1:0] c;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic dv, input logic fs, input logic d,
                     input logic [3:0] o, input logic fv, input logic se,
                     input logic [1:0] sl, input logic lk, input logic [1:0] c);
    vec_t v;
    v.dv = dv; v.fs = fs; v.d = d; v.o = o; v.fv = fv; v.se = se;
    v.sl = sl; v.lk = lk; v.c = c;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic dv, input logic fs, input logic d);
    @(negedge clk);
    din_valid = dv; frame_start = fs; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] o, input logic fv,
                           input logic se, input logic [1:0] sl, input logic lk,
                           input logic [1:0] c);
    chk({tag, ".out"},   8'(out), 8'(o));
    chk({tag, ".fv"},    8'(frame_valid), 8'(fv));
    chk({tag, ".se"},    8'(sync_err), 8'(se));
    chk({tag, ".slot"},  8'(slot), 8'(sl));
    chk({tag, ".lock"},  8'(locked), 8'(lk));
    chk({tag, ".cnt"},   8'(err_cnt), 8'(c));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b0; frame_start = 1'b0; din = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [1:0] sat_exp [5];

  initial begin
    // dv fs d  out   fv  se  slot lk cnt
    // frame (1,0,1,1) -> 1101
    add(1'b1,1'b1,1'b1, 4'h0,1'b0,1'b0,2'd1,1'b1,2'd0);
    add(1'b1,1'b0,1'b0, 4'h0,1'b0,1'b0,2'd2,1'b1,2'd0);
    add(1'b1,1'b0,1'b1, 4'h0,1'b0,1'b0,2'd3,1'b1,2'd0);
    add(1'b1,1'b0,1'b1, 4'hD,1'b1,1'b0,2'd0,1'b1,2'd0);
    // frame A again, then 3 idle cycles (one with fs high)
    add(1'b1,1'b1,1'b1, 4'hD,1'b0,1'b0,2'd1,1'b1,2'd0);
    add(1'b1,1'b0,1'b0, 4'hD,1'b0,1'b0,2'd2,1'b1,2'd0);
    add(1'b1,1'b0,1'b1, 4'hD,1'b0,1'b0,2'd3,1'b1,2'd0);
    add(1'b1,1'b0,1'b1, 4'hD,1'b1,1'b0,2'd0,1'b1,2'd0);
    add(1'b0,1'b0,1'b0, 4'hD,1'b0,1'b0,2'd0,1'b1,2'd0);
    add(1'b0,1'b1,1'b1, 4'hD,1'b0,1'b0,2'd0,1'b1,2'd0);
    add(1'b0,1'b0,1'b1, 4'hD,1'b0,1'b0,2'd0,1'b1,2'd0);
    // frame B (0,1,1,0) with gaps inside -> 0110
    add(1'b1,1'b1,1'b0, 4'hD,1'b0,1'b0,2'd1,1'b1,2'd0);
    add(1'b0,1'b0,1'b1, 4'hD,1'b0,1'b0,2'd1,1'b1,2'd0);
    add(1'b1,1'b0,1'b1, 4'hD,1'b0,1'b0,2'd2,1'b1,2'd0);
    add(1'b1,1'b0,1'b1, 4'hD,1'b0,1'b0,2'd3,1'b1,2'd0);
    add(1'b0,1'b1,1'b0, 4'hD,1'b0,1'b0,2'd3,1'b1,2'd0);
    add(1'b1,1'b0,1'b0, 4'h6,1'b1,1'b0,2'd0,1'b1,2'd0);
    // early marker at slot 2, restart frame (0,1,1,1) -> 1110
    add(1'b1,1'b1,1'b1, 4'h6,1'b0,1'b0,2'd1,1'b1,2'd0);
    add(1'b1,1'b0,1'b1, 4'h6,1'b0,1'b0,2'd2,1'b1,2'd0);
    add(1'b1,1'b1,1'b0, 4'h6,1'b0,1'b1,2'd1,1'b1,2'd1);
    add(1'b1,1'b0,1'b1, 4'h6,1'b0,1'b0,2'd2,1'b1,2'd1);
    add(1'b1,1'b0,1'b1, 4'h6,1'b0,1'b0,2'd3,1'b1,2'd1);
    add(1'b1,1'b0,1'b1, 4'hE,1'b1,1'b0,2'd0,1'b1,2'd1);
    // missing marker -> HUNT; fs=0 beats ignored
    add(1'b1,1'b0,1'b1, 4'hE,1'b0,1'b1,2'd0,1'b0,2'd2);
    add(1'b1,1'b0,1'b1, 4'hE,1'b0,1'b0,2'd0,1'b0,2'd2);
    add(1'b1,1'b0,1'b0, 4'hE,1'b0,1'b0,2'd0,1'b0,2'd2);
    // relock with frame (1,1,0,0) -> 0011
    add(1'b1,1'b1,1'b1, 4'hE,1'b0,1'b0,2'd1,1'b1,2'd2);
    add(1'b1,1'b0,1'b1, 4'hE,1'b0,1'b0,2'd2,1'b1,2'd2);
    add(1'b1,1'b0,1'b0, 4'hE,1'b0,1'b0,2'd3,1'b1,2'd2);
    add(1'b1,1'b0,1'b0, 4'h3,1'b1,1'b0,2'd0,1'b1,2'd2);
    // early marker at slot 3: no commit, restart; frame (1,0,0,1) -> 1001
    add(1'b1,1'b1,1'b1, 4'h3,1'b0,1'b0,2'd1,1'b1,2'd2);
    add(1'b1,1'b0,1'b0, 4'h3,1'b0,1'b0,2'd2,1'b1,2'd2);
    add(1'b1,1'b0,1'b0, 4'h3,1'b0,1'b0,2'd3,1'b1,2'd2);
    add(1'b1,1'b1,1'b1, 4'h3,1'b0,1'b1,2'd1,1'b1,2'd3);
    add(1'b1,1'b0,1'b0, 4'h3,1'b0,1'b0,2'd2,1'b1,2'd3);
    add(1'b1,1'b0,1'b0, 4'h3,1'b0,1'b0,2'd3,1'b1,2'd3);
    add(1'b1,1'b0,1'b1, 4'h9,1'b1,1'b0,2'd0,1'b1,2'd3);
    // lost sync with counter already saturated
    add(1'b1,1'b0,1'b0, 4'h9,1'b0,1'b1,2'd0,1'b0,2'd3);

    rst = 1'b1; din_valid = 1'b0; frame_start = 1'b0; din = 1'b0;
    #12;
    check_all("reset", 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      beat(tbl[i].dv, tbl[i].fs, tbl[i].d);
      check_all($sformatf("row%0d", i), tbl[i].o, tbl[i].fv, tbl[i].se,
                tbl[i].sl, tbl[i].lk, tbl[i].c);
    end

    // Async reset mid-frame: out is 1001 and err_cnt 3 going in.
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b1);
    chk("pre_rst.slot", 8'(slot), 8'd2);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    beat(1'b1, 1'b0, 1'b1);
    check_all("post_rst_hunt", 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0);
    check_all("post_rst_s3", 4'h0, 1'b0, 1'b0, 2'd3, 1'b1, 2'd0);
    beat(1'b1, 1'b0, 1'b1);
    check_all("post_rst_frame", 4'h8, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0);
    beat(1'b0, 1'b0, 1'b0);
    chk("fv_pulse_len", 8'(frame_valid), 8'd0);

    // Saturation: five lost-sync events from reset.
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      beat(1'b1, 1'b1, 1'b1);
      beat(1'b1, 1'b0, 1'b0);
      beat(1'b1, 1'b0, 1'b1);
      beat(1'b1, 1'b0, 1'b0);
      chk($sformatf("sat%0d.fv", k), 8'(frame_valid), 8'd1);
      chk($sformatf("sat%0d.out", k), 8'(out), 8'h5);
      beat(1'b1, 1'b0, 1'b1);
      chk($sformatf("sat%0d.se", k), 8'(sync_err), 8'd1);
      chk($sformatf("sat%0d.cnt", k), 8'(err_cnt), 8'(sat_exp[k]));
      chk($sformatf("sat%0d.lock", k), 8'(locked), 8'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Stops a hung run from going on forever.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
